// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: default widths, data memory size and
// the memory dumper FSM state encoding.
package debug_pkg;

  localparam int unsigned DEF_NB_DATA    = 32;
  localparam int unsigned DEF_NB_BYTE    = 8;
  localparam int unsigned DATA_MEM_SLOTS = 128;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StLatch  = 3'd2,
    StSend   = 3'd3,
    StWaitTx = 3'd4,
    StDone   = 3'd5
  } dumper_state_e;

endpackage

// File: rtl/word_serializer.sv
// Holds one memory word and presents it a byte at a time, least significant
// byte first. o_last flags the final byte of the word.
module word_serializer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_next,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last
);

  localparam int unsigned BytesPerWord = NB_DATA / NB_BYTE;
  localparam int unsigned NbIdx        = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

  logic [NB_DATA-1:0] word_q, word_d;
  logic [NbIdx-1:0]   idx_q, idx_d;

  // Load restarts at byte 0; next steps the index.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_load) begin
      word_d = i_word;
      idx_d  = '0;
    end else if (i_next) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Word and byte index registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign o_byte = word_q[32'(idx_q) * NB_BYTE +: NB_BYTE];
  assign o_last = (idx_q == NbIdx'(BytesPerWord - 1));

endmodule

// File: rtl/debug_mem_dumper.sv
// Walks the data memory through its debug read port and streams every word
// to the debug UART transmitter, least significant byte first.
module debug_mem_dumper
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA        = DEF_NB_DATA,
  parameter int unsigned NB_BYTE        = DEF_NB_BYTE,
  parameter int unsigned NUM_SLOTS      = DATA_MEM_SLOTS,
  parameter int unsigned NUM_DIREC      = $clog2(NUM_SLOTS),
  parameter int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_DATA-1:0]   i_debug_read_mem,
  output logic [NUM_DIREC-1:0] o_debug_read_mem_address,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  // Address of the last word; the dump ends there instead of wrapping.
  localparam logic [NUM_DIREC-1:0] LastAddr = NUM_DIREC'(NUM_SLOTS - BYTES_PER_WORD);
  localparam logic [NUM_DIREC-1:0] AddrStep = NUM_DIREC'(BYTES_PER_WORD);

  dumper_state_e        state_q, state_d;
  logic [NUM_DIREC-1:0] addr_q, addr_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;

  logic               ser_load;
  logic               ser_next;
  logic [NB_BYTE-1:0] ser_byte;
  logic               ser_last;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_next  (ser_next),
    .i_word  (i_debug_read_mem),
    .o_byte  (ser_byte),
    .o_last  (ser_last)
  );

  // Next-state logic: memory read, latch, per-byte handshake with the UART.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ser_load   = 1'b0;
    ser_next   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = StRead;
        end
      end
      // Memory output settles one cycle after the address moves.
      StRead:  state_d = StLatch;
      StLatch: begin
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        tx_data_d  = ser_byte;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (i_tx_done) begin
          if (!ser_last) begin
            ser_next = 1'b1;
            state_d  = StSend;
          end else if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + AddrStep;
            state_d = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, address and registered UART outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_debug_read_mem_address = addr_q;
  assign o_tx_data                = tx_data_q;
  assign o_tx_start               = tx_start_q;
  assign o_busy                   = (state_q != StIdle) && (state_q != StDone);
  assign o_done                   = (state_q == StDone);

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Bench for debug_mem_dumper: memory model, UART model and a byte scoreboard.
module tb_debug_mem_dumper;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rd_data;
  logic [6:0]  addr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        uart_done;
  logic        spur_done;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0] data;
    logic [6:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  int          n_cmp    = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  int          tx_seen  = 0;

  always #5 clock = ~clock;

  assign tx_done = uart_done | spur_done;

  debug_mem_dumper dut (
    .i_clock                  (clock),
    .i_reset                  (reset),
    .i_start                  (start),
    .i_debug_read_mem         (rd_data),
    .o_debug_read_mem_address (addr),
    .o_tx_data                (tx_data),
    .o_tx_start               (tx_start),
    .i_tx_done                (tx_done),
    .o_busy                   (busy),
    .o_done                   (done)
  );

  // Memory debug port updates on the falling edge.
  always @(negedge clock) rd_data <= mem[addr[6:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input bit custom_first);
    logic [7:0] c [4];
    exp_t e;
    c = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int k = 0; k < 128; k++) begin
      e.data = (custom_first && k < 4) ? c[k] : 8'(k);
      e.addr = 7'(k & ~3);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit with_done);
    @(negedge clock);
    start = 1'b1;
    spur_done = with_done;
    @(negedge clock);
    start = 1'b0;
    spur_done = 1'b0;
  endtask

  task automatic wait_done(input int exp);
    int t;
    t = 0;
    while (done_cnt < exp && t < 4000) begin
      @(posedge clock);
      t++;
    end
    check("done_count", done_cnt, exp);
    @(negedge clock);
    check("busy_after_done", {31'b0, busy}, 0);
    check("done_single_pulse", {31'b0, done}, 0);
    repeat (4) @(negedge clock);
    check("done_count_stable", done_cnt, exp);
  endtask

  // UART model: i_tx_done pulses 5 cycles after each o_tx_start.
  initial begin
    int uart_cnt;
    uart_cnt  = 0;
    uart_done = 1'b0;
    forever begin
      @(negedge clock);
      uart_done = 1'b0;
      if (reset) begin
        uart_cnt = 0;
      end else if (uart_cnt != 0) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_done = 1'b1;
      end else if (tx_start) begin
        uart_cnt = 5;
      end
    end
  end

  // Monitor: every byte handed to the UART is compared with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (tx_start) begin
          tx_seen++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_byte: got %0h at addr %0h expected no byte", tx_data, addr);
          end else begin
            e = sb.pop_front();
            check("tx_byte", {24'b0, tx_data}, {24'b0, e.data});
            check("tx_addr", {25'b0, addr}, {25'b0, e.addr});
          end
        end
        if (done) begin
          done_cnt++;
          check("sb_empty_at_done", sb.size(), 0);
        end
      end
    end
  end

  initial begin
    int t;
    int lat;
    reset     = 1'b1;
    start     = 1'b0;
    spur_done = 1'b0;
    for (int w = 0; w < 32; w++) begin
      mem[w] = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle after reset.
    repeat (10) @(negedge clock);
    check("idle_tx_start", {31'b0, tx_start}, 0);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_addr", {25'b0, addr}, 0);
    check("idle_tx_data", {24'b0, tx_data}, 0);
    check("idle_done", {31'b0, done}, 0);

    // Byte order within a word and start-to-first-byte latency.
    mem[0] = 32'hDDCCBBAA;
    push_dump(1'b1);
    tx_seen = 0;
    pulse_start(1'b0);
    lat = 0;
    while (!tx_start && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("first_tx_latency", lat, 3);
    check("busy_during_dump", {31'b0, busy}, 1);
    wait_done(1);
    mem[0] = 32'h03020100;

    // Restart attempt in WAIT_TX of byte 5, spurious done while in READ.
    push_dump(1'b0);
    tx_seen = 0;
    pulse_start(1'b0);
    t = 0;
    while (tx_seen < 6 && t < 200) begin
      @(posedge clock);
      t++;
    end
    check("reached_byte5", {31'b0, tx_seen >= 6}, 1);
    pulse_start(1'b0);
    t = 0;
    while (!(tx_seen >= 8 && tx_done) && t < 200) begin
      @(posedge clock);
      t++;
    end
    check("word1_last_done", {31'b0, tx_done}, 1);
    @(negedge clock);
    spur_done = 1'b1;
    @(negedge clock);
    spur_done = 1'b0;
    wait_done(2);

    // Asynchronous reset during byte 40, then a clean restart.
    push_dump(1'b0);
    tx_seen = 0;
    pulse_start(1'b0);
    t = 0;
    while (tx_seen < 41 && t < 1000) begin
      @(posedge clock);
      t++;
    end
    @(negedge clock);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_addr", {25'b0, addr}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_done", {31'b0, done}, 0);
    repeat (3) @(negedge clock);
    check("no_done_after_reset", done_cnt, 2);
    reset = 1'b0;
    push_dump(1'b0);
    // Start coincides with a stray tx_done in IDLE; start must win.
    pulse_start(1'b1);
    wait_done(3);

    check("sb_final_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_mem_dumper.md
Name: debug_mem_dumper

Overview:
- Debug-path consumer of the data memory's debug read port.
- On a start request it walks the whole data memory word by word via the debug address.
- Each word is serialised as 4 bytes, least significant first, to the debug UART transmitter.
- Sits between data memory (debug port) and uart_tx, under control of the debug unit FSM.

Parameters:
- NB_DATA, 32, data word width.
- NB_BYTE, 8, byte width and UART payload width.
- NUM_SLOTS, 128, data memory size in bytes.
- NUM_DIREC, $clog2(NUM_SLOTS), byte address width.
- BYTES_PER_WORD, NB_DATA/NB_BYTE, bytes sent per word.

Ports:
- i_clock  in  1  system clock; all state on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a dump; ignored unless IDLE.
- i_debug_read_mem  in  NB_DATA  word from data memory debug port; valid one full cycle after address change.
- o_debug_read_mem_address  out  NUM_DIREC  byte address driven to data memory debug port.
- o_tx_data  out  NB_BYTE  byte presented to UART tx.
- o_tx_start  out  1  one-cycle pulse; UART latches o_tx_data.
- i_tx_done  in  1  one-cycle pulse from UART when the byte is fully sent.
- o_busy  out  1  high from the cycle after accepted i_start until DONE.
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset (async): state IDLE; address 0; word reg 0; byte index 0; o_tx_data 0; o_tx_start 0; o_busy 0; o_done 0.
- FSM states and transitions:
  - IDLE: on i_start, address <= 0, go READ.
  - READ: wait one cycle (memory updates on negedge), then go LATCH.
  - LATCH: word_reg <= i_debug_read_mem; byte index <= 0; go SEND.
  - SEND: o_tx_data <= word_reg[byte_idx*NB_BYTE +: NB_BYTE]; o_tx_start pulses 1 cycle; go WAIT_TX.
  - WAIT_TX, on i_tx_done:
    - If byte_idx < 3: byte_idx++ and go SEND.
    - Else if address == NUM_SLOTS-4: go DONE.
    - Else: address += 4 and go READ.
  - DONE: o_done = 1 for one cycle; go IDLE.
- Latency:
  - i_start sampled at edge N -> READ at N+1, LATCH at N+2, first o_tx_start asserted in the cycle after N+3.
  - Each subsequent byte: one cycle from i_tx_done to o_tx_start.
- o_tx_start is a registered output.
- o_tx_data is held stable from SEND until the next SEND.
- Address arithmetic:
  - Unsigned, NUM_DIREC bits; never wraps.
  - Terminal compare is against NUM_SLOTS-4, so the last word read is bytes 124..127 (default).
- Total transfer is NUM_SLOTS bytes (default 128), i.e. NUM_SLOTS/4 words.
- Edge cases:
  - i_start while not IDLE: ignored, no restart.
  - i_tx_done outside WAIT_TX: ignored.
  - i_tx_done in the same cycle as o_tx_start: ignored; the FSM is in SEND, not WAIT_TX.
  - i_start and i_tx_done in the same cycle in IDLE: start is accepted.
  - Reset mid-dump: immediate return to IDLE with all outputs at reset values; no o_done.
- o_debug_read_mem_address is held during WAIT_TX; the memory content may change, but word_reg is already latched.

Decomposition:
- Shared package debug_pkg holds:
  - FSM state encodings (IDLE, READ, LATCH, SEND, WAIT_TX, DONE; 3-bit).
  - NB_BYTE and NB_DATA defaults.
  - DATA_MEM_SLOTS = 128.
- Optional sub-module word_serializer: word register, byte index and byte mux, with load/next/last signals.
- The FSM stays in debug_mem_dumper.

Test Plan:
- Reset, then idle 10 cycles -> o_tx_start = 0, o_busy = 0, address = 0, o_tx_data = 0.
- Memory model with word at byte 0 = 0xDDCCBBAA; i_start; UART model returns i_tx_done 5 cycles after each o_tx_start:
  - Bytes sent in order 0xAA, 0xBB, 0xCC, 0xDD.
  - First o_tx_start exactly 3 cycles after i_start.
- Full dump with memory byte k = k:
  - Exactly 128 o_tx_start pulses carrying bytes 0x00..0x7F in order.
  - Addresses 0, 4, ..., 124.
  - One o_done pulse after the 128th i_tx_done; o_busy then falls.
- i_start re-asserted during WAIT_TX of byte 5 -> no restart; sequence continues with byte 6.
- Spurious i_tx_done while in READ -> ignored; byte count and order unchanged.
- Async reset asserted mid-cycle during byte 40 -> outputs clear immediately, no o_done; a new i_start restarts from address 0 with byte 0x00.
